// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encodings, handshake levels
// and the EX aluop codes that select the divider.
package div_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

   localparam logic [7:0] ExeDivOp  = 8'b0001_1010;
   localparam logic [7:0] ExeDivuOp = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract, shift in a quotient bit.
// Ports: work_i (low 2*WIDTH bits of working reg), divisor_i, work_o (next reg).
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] work_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic [2*WIDTH:0]   work_o
);

   logic [WIDTH:0] diff;

   // The extra top bit of diff is the borrow: set means the trial failed.
   assign diff = {1'b0, work_i[2*WIDTH-1:WIDTH]} - {1'b0, divisor_i};

   assign work_o = diff[WIDTH]
                 ? {work_i, 1'b0}
                 : {diff[WIDTH-1:0], work_i[WIDTH-1:0], 1'b1};

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider, one quotient bit per clock.
// Ports: clk, rst, signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
//        result_o {rem, quo}, ready_o.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CntW = $clog2(WIDTH + 1);

   div_state_e       state_q;
   logic [CntW-1:0]  cnt_q;
   logic [2*WIDTH:0] work_q;
   logic [2*WIDTH:0] work_d;
   logic [WIDTH-1:0] divisor_q;
   logic             neg1_q;
   logic             neg2_q;

   logic             neg1;
   logic             neg2;
   logic [WIDTH-1:0] op1_abs;
   logic [WIDTH-1:0] op2_abs;
   logic [WIDTH-1:0] quo_raw;
   logic [WIDTH-1:0] rem_raw;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
   assign neg2 = signed_div_i & opdata2_i[WIDTH-1];

   // MIN negates to itself, which read unsigned is the right magnitude.
   assign op1_abs = neg1 ? -opdata1_i : opdata1_i;
   assign op2_abs = neg2 ? -opdata2_i : opdata2_i;

   assign quo_raw = work_q[WIDTH-1:0];
   assign rem_raw = work_q[2*WIDTH:WIDTH+1];

   // Quotient sign follows sign mismatch, remainder follows the dividend.
   assign quo_fix = (neg1_q ^ neg2_q) ? -quo_raw : quo_raw;
   assign rem_fix = neg1_q ? -rem_raw : rem_raw;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .work_i   (work_q[2*WIDTH-1:0]),
      .divisor_i(divisor_q),
      .work_o   (work_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         neg1_q    <= 1'b0;
         neg2_q    <= 1'b0;
         result_o  <= '0;
         ready_o   <= DivResultNotReady;
      end else begin
         unique case (state_q)
            DivFree: begin
               if (start_i == DivStart && !annul_i) begin
                  neg1_q    <= neg1;
                  neg2_q    <= neg2;
                  divisor_q <= op2_abs;
                  work_q    <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
                  cnt_q     <= '0;
                  if (opdata2_i == '0) begin
                     state_q <= DivByZero;
                  end else begin
                     state_q <= DivOn;
                  end
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else begin
                  result_o <= '0;
                  ready_o  <= DivResultReady;
                  state_q  <= DivEnd;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else if (cnt_q != CntW'(WIDTH)) begin
                  work_q <= work_d;
                  cnt_q  <= cnt_q + CntW'(1);
               end else begin
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= DivResultReady;
                  state_q  <= DivEnd;
               end
            end
            DivEnd: begin
               if (start_i == DivStop) begin
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
                  state_q  <= DivFree;
               end
            end
            default: state_q <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed + random bench for div_unit at WIDTH=32 and WIDTH=8,
// scoreboard of expected {rem, quo} and latency per operation.
module tb_div_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  = 1'b1;
   logic        s32  = 1'b0;
   logic [31:0] a32  = '0;
   logic [31:0] b32  = '0;
   logic        st32 = 1'b0;
   logic        an32 = 1'b0;
   logic [63:0] res32;
   logic        r32;

   logic        s8  = 1'b0;
   logic [7:0]  a8  = '0;
   logic [7:0]  b8  = '0;
   logic        st8 = 1'b0;
   logic        an8 = 1'b0;
   logic [15:0] res8;
   logic        r8;

   logic [63:0] exp_q[$];
   int          lat_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   div_unit #(.WIDTH(32)) u_d32 (
      .clk         (clk),
      .rst         (rst),
      .signed_div_i(s32),
      .opdata1_i   (a32),
      .opdata2_i   (b32),
      .start_i     (st32),
      .annul_i     (an32),
      .result_o    (res32),
      .ready_o     (r32)
   );

   div_unit #(.WIDTH(8)) u_d8 (
      .clk         (clk),
      .rst         (rst),
      .signed_div_i(s8),
      .opdata1_i   (a8),
      .opdata2_i   (b8),
      .start_i     (st8),
      .annul_i     (an8),
      .result_o    (res8),
      .ready_o     (r8)
   );

   function automatic logic [63:0] model(int w, bit s,
                                         logic [31:0] a, logic [31:0] b);
      longint mask;
      longint sa;
      longint sb;
      longint q;
      longint r;
      mask = (longint'(1) << w) - 1;
      sa = longint'({32'b0, a}) & mask;
      sb = longint'({32'b0, b}) & mask;
      if (s && sa[w-1]) sa = sa - (longint'(1) << w);
      if (s && sb[w-1]) sb = sb - (longint'(1) << w);
      if (sb == 0) return 64'd0;
      q = sa / sb;
      r = sa % sb;
      return 64'(((r & mask) << w) | (q & mask));
   endfunction

   function automatic logic rdy(bit sel);
      return sel ? r8 : r32;
   endfunction

   function automatic logic [63:0] res(bit sel);
      return sel ? {48'b0, res8} : res32;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_start(bit sel, logic v);
      if (sel) st8 = v;
      else st32 = v;
   endtask

   task automatic scramble(bit sel);
      if (sel) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         s8 = 1'($urandom_range(0, 1));
      end else begin
         a32 = $urandom;
         b32 = $urandom;
         s32 = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic start_op(bit sel, bit s, logic [31:0] a,
                           logic [31:0] b, logic [63:0] exp);
      bit zero;
      @(negedge clk);
      zero = sel ? (b[7:0] == 8'd0) : (b == 32'd0);
      exp_q.push_back(exp);
      lat_q.push_back(zero ? 1 : (sel ? 9 : 33));
      if (sel) begin
         s8 = s; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1;
      end else begin
         s32 = s; a32 = a; b32 = b; st32 = 1'b1;
      end
   endtask

   // Counts edges after E0 until ready_o, then checks hold and release.
   task automatic finish_op(bit sel, string tag);
      logic [63:0] e;
      int          el;
      int          k;
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      k  = 0;
      forever begin
         @(posedge clk); #1;
         if (k == 0) scramble(sel);
         if (rdy(sel)) break;
         k++;
         if (k > 80) break;
      end
      chk({tag, "/lat"}, 64'(k), 64'(el));
      chk({tag, "/res"}, res(sel), e);
      @(posedge clk); #1;
      chk({tag, "/hold_rdy"}, 64'(rdy(sel)), 64'd1);
      chk({tag, "/hold_res"}, res(sel), e);
      set_start(sel, 1'b0);
      @(posedge clk); #1;
      chk({tag, "/rel_rdy"}, 64'(rdy(sel)), 64'd0);
      chk({tag, "/rel_res"}, res(sel), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      logic [31:0] ra;
      logic [31:0] rb;
      bit rs;

      repeat (2) @(posedge clk);
      #1;
      chk("reset/r32", 64'(r32), 64'd0);
      chk("reset/res32", res32, 64'd0);
      chk("reset/r8", 64'(r8), 64'd0);
      chk("reset/res8", res(1'b1), 64'd0);
      rst = 1'b0;

      start_op(0, 0, 32'd100, 32'd7, {32'd2, 32'd14});
      finish_op(0, "u100_7");

      start_op(0, 1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
      finish_op(0, "s-7_2");

      start_op(0, 1, 32'd7, -32'sd2, {32'd1, 32'hFFFFFFFD});
      finish_op(0, "s7_-2");

      start_op(0, 0, 32'd5, 32'd0, 64'd0);
      finish_op(0, "u_div0");

      start_op(0, 1, -32'sd5, 32'd0, 64'd0);
      finish_op(0, "s_div0");

      start_op(0, 1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
      finish_op(0, "min_m1");

      // Annul mid-division; scoreboard entry is dropped with the op.
      start_op(0, 0, 32'd1000, 32'd3, {32'd1, 32'd333});
      repeat (10) @(posedge clk);
      #1;
      an32 = 1'b1;
      st32 = 1'b0;
      @(posedge clk); #1;
      an32 = 1'b0;
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      chk("annul/rdy", 64'(r32), 64'd0);
      chk("annul/res", res32, 64'd0);
      hi = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (r32) hi++;
      end
      chk("annul/never", 64'(hi), 64'd0);
      start_op(0, 0, 32'd1000, 32'd3, {32'd1, 32'd333});
      finish_op(0, "after_annul");

      // annul held in FREE must keep the start from being taken.
      an32 = 1'b1;
      start_op(0, 0, 32'd9, 32'd4, {32'd1, 32'd2});
      repeat (3) @(posedge clk);
      @(negedge clk);
      an32 = 1'b0;
      finish_op(0, "annul_free");

      // Reset mid-op with start held: op restarts after reset.
      start_op(0, 0, 32'd500, 32'd7, {32'd3, 32'd71});
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst/rdy", 64'(r32), 64'd0);
      chk("midrst/res", res32, 64'd0);
      rst = 1'b0;
      finish_op(0, "after_rst");

      start_op(1, 0, 32'hFF, 32'h10, 64'h0F0F);
      finish_op(1, "w8_ff_10");

      start_op(1, 1, 32'h80, 32'hFF, 64'h0080);
      finish_op(1, "w8_min_m1");

      for (int i = 0; i < 30; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = {24'b0, 8'($urandom)};
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : {24'b0, 8'($urandom)};
         start_op(1, rs, ra, rb, model(8, rs, ra, rb));
         finish_op(1, "w8_rand");
      end

      for (int i = 0; i < 6; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 30));
         start_op(0, rs, ra, rb, model(32, rs, ra, rb));
         finish_op(0, "w32_rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
